// File: rtl/axi4_pkg.sv
`default_nettype none
//============================================================================
// Module : axi4_pkg
// Shared AXI4 burst/response encodings and responder state type.
// Rev    : 1.0
//============================================================================
package axi4_pkg;

    typedef enum logic [1:0] {
        FIXED  = 2'b00,
        INCR   = 2'b01,
        WRAP   = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_READ  = 3'd2,
        ST_WDATA = 3'd3,
        ST_BRESP = 3'd4
    } rsp_state_t;

endpackage
`default_nettype wire

// File: rtl/axi4_if.sv
`default_nettype none
//============================================================================
// Module : axi4_if
// AXI4 AW/W/B/AR/R channel bundle with master and slave views.
// Rev    : 1.0
//============================================================================
interface axi4_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output awready, wready, bid, bresp, bvalid,
        output arready, rid, rdata, rresp, rlast, rvalid
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/axi4_burst_addr_gen.sv
`default_nettype none
//============================================================================
// Module : axi4_burst_addr_gen
// Combinational next-beat address for FIXED/INCR/WRAP bursts.
// Rev    : 1.0
//============================================================================
module axi4_burst_addr_gen
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [7:0]            len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);
    logic [ADDR_WIDTH-1:0] w_stride;
    logic [ADDR_WIDTH-1:0] w_incr;
    logic [ADDR_WIDTH-1:0] w_mask;
    logic                  w_wrap_len_ok;

    always_comb begin
        w_stride      = ADDR_WIDTH'(1) << size;
        w_incr        = addr + w_stride;
        w_mask        = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        w_wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        next_addr     = w_incr;
        if (burst == FIXED) begin
            next_addr = addr;
        end else if ((burst == WRAP) && w_wrap_len_ok) begin
            // Keep the block-aligned upper bits, let only the in-block offset roll over.
            next_addr = (addr & ~w_mask) | (w_incr & w_mask);
        end
    end
endmodule
`default_nettype wire

// File: rtl/ifu_axi_rd_responder.sv
`default_nettype none
//============================================================================
// Module : ifu_axi_rd_responder
// AXI4 read-burst slave in front of a 1-cycle instruction SRAM; writes get SLVERR.
// Rev    : 1.0
//============================================================================
module ifu_axi_rd_responder
    import axi4_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    ID_WIDTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h3000_0000,
    parameter logic [ADDR_WIDTH-1:0] MEM_BYTES  = 32'h0001_0000,
    parameter int                    LATENCY    = 0
) (
    input  logic                                        clock,
    input  logic                                        reset,
    axi4_if.slave                                       axi,
    output logic                                        mem_en,
    output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0]  mem_addr,
    input  logic [DATA_WIDTH-1:0]                       mem_rdata
);
    localparam int         c_word_lsb  = $clog2(DATA_WIDTH / 8);
    localparam logic [3:0] c_wait_init = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    rsp_state_t            r_state;
    rsp_state_t            w_state_nxt;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ID_WIDTH-1:0]   r_bid;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [ADDR_WIDTH-1:0] w_off;
    logic [7:0]            r_len;
    logic [7:0]            r_cnt;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  r_all_issued;
    logic [3:0]            r_wait;
    logic                  r_rvalid;
    logic                  r_rlast;
    logic                  r_data_ok;
    resp_t                 r_rresp;
    logic                  w_issue;
    logic                  w_beat_ok;
    logic                  w_last_fire;
    logic                  w_unused;

    axi4_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .addr      (r_addr),
        .size      (r_size),
        .len       (r_len),
        .burst     (r_burst),
        .next_addr (w_addr_nxt)
    );

    assign w_off       = r_addr - BASE_ADDR;
    assign w_beat_ok   = (w_off < MEM_BYTES) && (r_size <= 3'(c_word_lsb));
    assign w_issue     = (r_state == ST_READ) && !r_all_issued && (!r_rvalid || axi.rready);
    assign w_last_fire = r_rvalid && axi.rready && r_rlast;

    assign mem_en   = w_issue && w_beat_ok;
    assign mem_addr = w_off[ADDR_WIDTH-1:c_word_lsb];

    assign axi.arready = (r_state == ST_IDLE) && !reset;
    assign axi.awready = (r_state == ST_IDLE) && !reset && !axi.arvalid;
    assign axi.wready  = (r_state == ST_WDATA);
    assign axi.bvalid  = (r_state == ST_BRESP);
    assign axi.bresp   = (r_state == ST_BRESP) ? SLVERR : OKAY;
    assign axi.bid     = r_bid;
    assign axi.rvalid  = r_rvalid;
    assign axi.rlast   = r_rlast;
    assign axi.rresp   = r_rresp;
    assign axi.rid     = r_id;
    // The SRAM holds its output until the next read, so a stalled beat stays stable.
    assign axi.rdata   = r_data_ok ? mem_rdata : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (axi.arvalid) begin
                    w_state_nxt = (LATENCY > 0) ? ST_WAIT : ST_READ;
                end else if (axi.awvalid) begin
                    w_state_nxt = ST_WDATA;
                end
            end
            ST_WAIT:  if (r_wait == 4'd0) w_state_nxt = ST_READ;
            ST_READ:  if (w_last_fire) w_state_nxt = ST_IDLE;
            ST_WDATA: if (axi.wvalid && axi.wlast) w_state_nxt = ST_BRESP;
            ST_BRESP: if (axi.bready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_id         <= '0;
            r_bid        <= '0;
            r_addr       <= '0;
            r_len        <= '0;
            r_cnt        <= '0;
            r_size       <= '0;
            r_burst      <= '0;
            r_all_issued <= 1'b1;
            r_wait       <= '0;
            r_rvalid     <= 1'b0;
            r_rlast      <= 1'b0;
            r_data_ok    <= 1'b0;
            r_rresp      <= OKAY;
        end else begin
            if ((r_state == ST_IDLE) && axi.arvalid) begin
                r_id         <= axi.arid;
                r_addr       <= axi.araddr;
                r_len        <= axi.arlen;
                r_cnt        <= axi.arlen;
                r_size       <= axi.arsize;
                r_burst      <= axi.arburst;
                r_all_issued <= 1'b0;
                r_wait       <= c_wait_init;
            end
            if ((r_state == ST_IDLE) && !axi.arvalid && axi.awvalid) begin
                r_bid <= axi.awid;
            end
            if (r_state == ST_WAIT) begin
                r_wait <= r_wait - 4'd1;
            end
            if (w_issue) begin
                r_addr    <= w_addr_nxt;
                r_rlast   <= (r_cnt == 8'd0);
                r_rresp   <= w_beat_ok ? OKAY : SLVERR;
                r_data_ok <= w_beat_ok;
                if (r_cnt == 8'd0) begin
                    r_all_issued <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - 8'd1;
                end
            end
            r_rvalid <= w_issue || (r_rvalid && !axi.rready);
        end
    end

    assign w_unused = ^{axi.awaddr, axi.awlen, axi.awsize, axi.awburst,
                        axi.wdata, axi.wstrb, w_off[c_word_lsb-1:0]};
endmodule
`default_nettype wire

// File: tb/tb_ifu_axi_rd_responder.sv
`default_nettype none
//============================================================================
// Module : tb_ifu_axi_rd_responder
// Randomized bench for ifu_axi_rd_responder against a burst-level reference model.
// Rev    : 1.0
//============================================================================
module tb_ifu_axi_rd_responder;
    import axi4_pkg::*;

    localparam logic [31:0] c_base = 32'h3000_0000;
    localparam logic [31:0] c_mem  = 32'h0001_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_en;
    logic [29:0] mem_addr;
    logic [31:0] mem_rdata;
    int          total = 0;
    int          bad   = 0;

    axi4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) axi_bus ();

    ifu_axi_rd_responder #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .ID_WIDTH   (4),
        .BASE_ADDR  (c_base),
        .MEM_BYTES  (c_mem),
        .LATENCY    (0)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .axi       (axi_bus),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] word_of(input logic [29:0] idx);
        return {idx[15:0] ^ 16'hC3A5, idx[15:0]};
    endfunction

    // Single-port SRAM: data one cycle after the read enable, held otherwise.
    always @(posedge clock) if (mem_en) mem_rdata <= word_of(mem_addr);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Address of beat i computed directly from the burst rules.
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                              input int size, input int burst, input int i);
        logic [31:0] stride, block, base;
        stride = 32'd1 << size;
        if (burst == 0) return start;
        if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            block = 32'(len + 1) << size;
            base  = start & ~(block - 32'd1);
            return base + ((start - base + 32'(i) * stride) % block);
        end
        return start + 32'(i) * stride;
    endfunction

    // mode 0: rready high; 1: rready pattern 1,0,0,1; 2: random rready
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode,
                           input bit also_aw);
        logic [31:0] e_data [256];
        logic [1:0]  e_resp [256];
        logic [31:0] a, pd;
        logic [1:0]  pr;
        logic        pl, ok, rdy, stall;
        logic [3:0]  pat;
        int          k, cyc;
        pat = 4'b1001;
        for (int i = 0; i <= int'(len); i++) begin
            a         = beat_addr(addr, int'(len), int'(size), int'(burst), i);
            ok        = (size <= 3'd2) && ((a - c_base) < c_mem);
            e_data[i] = ok ? word_of(30'((a - c_base) >> 2)) : 32'd0;
            e_resp[i] = ok ? 2'b00 : 2'b10;
        end
        @(negedge clock);
        axi_bus.arvalid = 1'b1;
        axi_bus.arid    = id;
        axi_bus.araddr  = addr;
        axi_bus.arlen   = len;
        axi_bus.arsize  = size;
        axi_bus.arburst = burst;
        if (also_aw) begin
            axi_bus.awvalid = 1'b1;
            axi_bus.awid    = ~id;
        end
        #1;
        check("ar_ready", axi_bus.arready, 1);
        if (also_aw) check("aw_blocked_by_ar", axi_bus.awready, 0);
        @(posedge clock);
        #1;
        axi_bus.arvalid = 1'b0;
        axi_bus.awvalid = 1'b0;
        k = 0; cyc = 0; stall = 1'b0; pd = '0; pr = '0; pl = 1'b0;
        while (k <= int'(len) && cyc < 300) begin
            @(negedge clock);
            cyc++;
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? pat[(cyc - 1) % 4] : 1'($urandom_range(0, 1));
            axi_bus.rready = rdy;
            #1;
            if (stall) begin
                check("hold_rvalid", axi_bus.rvalid, 1);
                check("hold_rdata", axi_bus.rdata, pd);
                check("hold_rlast", axi_bus.rlast, pl);
                check("hold_rresp", axi_bus.rresp, pr);
            end
            stall = 1'b0;
            if (axi_bus.rvalid) begin
                if (mode == 0) check("beat_cycle", cyc, k + 2);
                if (rdy) begin
                    check("rdata", axi_bus.rdata, e_data[k]);
                    check("rresp", axi_bus.rresp, e_resp[k]);
                    check("rlast", axi_bus.rlast, (k == int'(len)) ? 1 : 0);
                    check("rid", axi_bus.rid, id);
                    k++;
                end else begin
                    check("stall_no_mem_en", mem_en, 0);
                    stall = 1'b1;
                    pd = axi_bus.rdata; pl = axi_bus.rlast; pr = axi_bus.rresp;
                end
            end
        end
        check("burst_beats", k, int'(len) + 1);
        @(negedge clock);
        axi_bus.rready = 1'b0;
        #1;
        check("rvalid_after_burst", axi_bus.rvalid, 0);
        check("arready_after_burst", axi_bus.arready, 1);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [7:0] len);
        @(negedge clock);
        axi_bus.awvalid = 1'b1;
        axi_bus.awid    = id;
        axi_bus.awlen   = len;
        axi_bus.awaddr  = c_base + 32'($urandom_range(0, 255)) * 4;
        #1;
        check("aw_ready", axi_bus.awready, 1);
        @(posedge clock);
        #1;
        axi_bus.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            @(negedge clock);
            axi_bus.wvalid = 1'b1;
            axi_bus.wlast  = (i == int'(len));
            axi_bus.wdata  = $urandom;
            #1;
            check("w_ready", axi_bus.wready, 1);
            check("no_bvalid_in_wdata", axi_bus.bvalid, 0);
            @(posedge clock);
            #1;
            axi_bus.wvalid = 1'b0;
            axi_bus.wlast  = 1'b0;
        end
        @(negedge clock);
        #1;
        check("bvalid", axi_bus.bvalid, 1);
        check("bresp", axi_bus.bresp, 2'b10);
        check("bid", axi_bus.bid, id);
        check("no_arready_in_bresp", axi_bus.arready, 0);
        axi_bus.bready = 1'b1;
        @(posedge clock);
        #1;
        axi_bus.bready = 1'b0;
        @(negedge clock);
        check("bvalid_cleared", axi_bus.bvalid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [31:0] addr;
        logic [2:0]  size;
        int          sel;
        reset = 1'b1;
        axi_bus.awid = '0; axi_bus.awaddr = '0; axi_bus.awlen = '0; axi_bus.awsize = 3'd2;
        axi_bus.awburst = 2'b01; axi_bus.awvalid = 1'b0;
        axi_bus.wdata = '0; axi_bus.wstrb = '1; axi_bus.wlast = 1'b0; axi_bus.wvalid = 1'b0;
        axi_bus.bready = 1'b0;
        axi_bus.arid = '0; axi_bus.araddr = '0; axi_bus.arlen = '0; axi_bus.arsize = '0;
        axi_bus.arburst = '0; axi_bus.arvalid = 1'b0; axi_bus.rready = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_arready", axi_bus.arready, 0);
        check("rst_awready", axi_bus.awready, 0);
        check("rst_wready", axi_bus.wready, 0);
        check("rst_rvalid", axi_bus.rvalid, 0);
        check("rst_rlast", axi_bus.rlast, 0);
        check("rst_rresp", axi_bus.rresp, 0);
        check("rst_rdata", axi_bus.rdata, 0);
        check("rst_rid", axi_bus.rid, 0);
        check("rst_bvalid", axi_bus.bvalid, 0);
        check("rst_bresp", axi_bus.bresp, 0);
        check("rst_bid", axi_bus.bid, 0);
        check("rst_mem_en", mem_en, 0);
        reset = 1'b0;
        #1;
        check("idle_arready", axi_bus.arready, 1);
        check("idle_awready", axi_bus.awready, 1);

        do_read(4'h3, c_base, 8'd3, 3'd2, 2'b01, 0, 1'b0);            // back-to-back INCR
        do_read(4'h4, c_base + 32'h8, 8'd3, 3'd2, 2'b10, 0, 1'b0);    // WRAP 08,0C,00,04
        do_read(4'h5, c_base + 32'h40, 8'd7, 3'd2, 2'b01, 1, 1'b0);   // backpressure
        do_read(4'h6, c_base + c_mem - 32'd4, 8'd1, 3'd2, 2'b01, 0, 1'b0);
        do_read(4'h7, c_base + 32'h20, 8'd2, 3'd2, 2'b00, 0, 1'b0);   // FIXED
        do_read(4'h8, c_base + 32'h10, 8'd1, 3'd3, 2'b01, 0, 1'b0);   // oversize beat
        do_read(4'h2, c_base + 32'h30, 8'd1, 3'd2, 2'b01, 0, 1'b1);   // AR beats AW
        do_write(4'hA, 8'd1);
        do_read(4'hB, c_base + 32'h80, 8'd3, 3'd2, 2'b01, 0, 1'b0);

        // Reset while beat 2 of an 8-beat burst is on the bus.
        @(negedge clock);
        axi_bus.arvalid = 1'b1; axi_bus.arid = 4'h5; axi_bus.araddr = c_base + 32'h100;
        axi_bus.arlen = 8'd7; axi_bus.arsize = 3'd2; axi_bus.arburst = 2'b01;
        axi_bus.rready = 1'b1;
        @(posedge clock);
        #1;
        axi_bus.arvalid = 1'b0;
        repeat (4) @(negedge clock);
        check("pre_rst_rvalid", axi_bus.rvalid, 1);
        check("pre_rst_rdata", axi_bus.rdata, word_of(30'h42));
        reset = 1'b1;
        #1;
        check("async_rst_rvalid", axi_bus.rvalid, 0);
        check("async_rst_arready", axi_bus.arready, 0);
        check("async_rst_mem_en", mem_en, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        axi_bus.rready = 1'b0;
        do_read(4'h9, c_base + 32'h200, 8'd3, 3'd2, 2'b01, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            sel  = int'($urandom_range(0, 11));
            size = 3'($urandom_range(0, 3));
            if (sel < 7)       addr = c_base + 32'($urandom_range(0, 16383)) * 4 + 32'($urandom_range(0, 3));
            else if (sel == 7) addr = c_base + c_mem - 32'($urandom_range(1, 4)) * 4;
            else if (sel == 8) addr = c_base - 32'($urandom_range(1, 4)) * 4;
            else if (sel == 9) addr = c_base + c_mem + 32'($urandom_range(0, 4)) * 4;
            else               addr = 32'h0;
            if (size <= 3'd2) addr = addr & ~((32'd1 << size) - 32'd1);
            if (sel == 10 || sel == 11) do_write(4'($urandom), 8'($urandom_range(0, 3)));
            else do_read(4'($urandom), addr, 8'($urandom_range(0, 15)), size,
                         2'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
